key_event_arb: RTL and testbench

KEY_EVENT_ARB -- requirements
Module: key_event_arb

---
 rtl/key_event_arb.sv | 128 ++++++++++++
 tb/tb_key_event_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arb.sv
`default_nettype none
// =============================================================================
// Module      : key_event_arb
// Description : Round-robin arbiter that queues key presses into an event FIFO
//               and counts presses lost while a key is already pending.
// Revision    : 1.0 - initial release
// =============================================================================
module key_event_arb #(
   parameter int N_KEY = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_KEY-1:0]           key_flag,
   input  logic                       clr_ovf,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [$clog2(N_KEY)-1:0]   ev_key,
   output logic [$clog2(DEPTH):0]     fifo_cnt,
   output logic                       ovf,
   output logic [7:0]                 drop_cnt
);

   localparam int c_KEY_W  = $clog2(N_KEY);
   localparam int c_ADDR_W = $clog2(DEPTH);

   logic [N_KEY-1:0]    r_pend;
   logic [c_KEY_W-1:0]  r_rr_ptr;
   logic [c_KEY_W-1:0]  r_mem [DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_ADDR_W:0]   r_cnt;
   logic                r_ovf;
   logic [7:0]          r_drop_cnt;

   logic                w_room;
   logic                w_grant;
   logic [c_KEY_W-1:0]  w_grant_idx;
   logic [c_KEY_W:0]    w_scan;
   logic [N_KEY-1:0]    w_grant_oh;
   logic                w_pop;
   logic [N_KEY-1:0]    w_drop;
   logic [c_KEY_W:0]    w_drop_num;
   logic [7:0]          w_drop_base;
   logic [8:0]          w_drop_sum;
   logic [7:0]          w_drop_next;
   logic [c_KEY_W-1:0]  w_rr_next;

   // Full is judged on the occupancy at the start of the cycle, so a
   // simultaneous pop never lets a grant through.
   assign w_room = (r_cnt != (c_ADDR_W+1)'(DEPTH));

   // Scan offsets high to low so the smallest offset from r_rr_ptr wins.
   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      if (w_room) begin
         for (int o = N_KEY-1; o >= 0; o--) begin
            w_scan = {1'b0, r_rr_ptr} + (c_KEY_W+1)'(o);
            if (w_scan >= (c_KEY_W+1)'(N_KEY)) begin
               w_scan = w_scan - (c_KEY_W+1)'(N_KEY);
            end
            if (r_pend[w_scan[c_KEY_W-1:0]]) begin
               w_grant     = 1'b1;
               w_grant_idx = w_scan[c_KEY_W-1:0];
            end
         end
      end
   end

   assign w_grant_oh = w_grant ? ({{(N_KEY-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
   assign w_rr_next  = (w_grant_idx == c_KEY_W'(N_KEY-1)) ? '0 : w_grant_idx + c_KEY_W'(1);
   assign w_pop      = (r_cnt != '0) && ev_ready;

   assign w_drop = key_flag & r_pend & ~w_grant_oh;

   always_comb begin
      w_drop_num = '0;
      for (int i = 0; i < N_KEY; i++) begin
         w_drop_num = w_drop_num + (c_KEY_W+1)'(w_drop[i]);
      end
   end

   assign w_drop_base = clr_ovf ? 8'd0 : r_drop_cnt;
   assign w_drop_sum  = {1'b0, w_drop_base} + 9'(w_drop_num);
   assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend     <= '0;
         r_rr_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_pend <= (r_pend & ~w_grant_oh) | key_flag;
         if (w_grant) begin
            r_mem[r_wr_ptr] <= w_grant_idx;
            r_wr_ptr        <= r_wr_ptr + c_ADDR_W'(1);
            r_rr_ptr        <= w_rr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
         end
         case ({w_grant, w_pop})
            2'b10:   r_cnt <= r_cnt + (c_ADDR_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (c_ADDR_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
         r_ovf      <= (r_ovf & ~clr_ovf) | (|w_drop);
         r_drop_cnt <= w_drop_next;
      end
   end

   assign ev_valid = (r_cnt != '0);
   assign ev_key   = r_mem[r_rd_ptr];
   assign fifo_cnt = r_cnt;
   assign ovf      = r_ovf;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_event_arb.sv
`default_nettype none
// Testbench for key_event_arb: directed scenarios plus random traffic, checked
// against a queue-based reference model by an independent negedge monitor.
module tb_key_event_arb;

   localparam int N = 4;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  key_flag;
   logic          clr_ovf;
   logic          ev_valid;
   logic          ev_ready;
   logic [1:0]    ev_key;
   logic [2:0]    fifo_cnt;
   logic          ovf;
   logic [7:0]    drop_cnt;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   bit m_pend [N];
   int m_rr   = 0;
   int m_cnt  = 0;
   int m_ovf  = 0;
   int m_drop = 0;
   int exp_q [$];

   logic [N-1:0] rnd_kf;

   key_event_arb #(.N_KEY(N), .DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_flag (key_flag),
      .clr_ovf  (clr_ovf),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_key   (ev_key),
      .fifo_cnt (fifo_cnt),
      .ovf      (ovf),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending set, round-robin pointer and event queue occupancy.
   always @(posedge clk) begin
      int g;
      int drops;
      bit pop;
      if (rst) begin
         m_pend = '{default: 1'b0};
         m_rr   = 0;
         m_cnt  = 0;
         m_ovf  = 0;
         m_drop = 0;
         exp_q.delete();
      end else begin
         g = -1;
         if (m_cnt < D) begin
            for (int o = 0; o < N; o++) begin
               if (g < 0 && m_pend[(m_rr + o) % N]) g = (m_rr + o) % N;
            end
         end
         drops = 0;
         for (int i = 0; i < N; i++) begin
            if (key_flag[i] && m_pend[i] && i != g) drops++;
         end
         pop = (m_cnt > 0) && ev_ready;
         if (g >= 0) begin
            exp_q.push_back(g);
            m_pend[g] = 1'b0;
            m_rr      = (g + 1) % N;
            m_cnt++;
         end
         if (pop) m_cnt--;
         for (int i = 0; i < N; i++) begin
            if (key_flag[i]) m_pend[i] = 1'b1;
         end
         if (clr_ovf) begin
            m_ovf  = 0;
            m_drop = 0;
         end
         if (drops > 0) begin
            m_ovf  = 1;
            m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ev_valid", int'(ev_valid), int'(m_cnt != 0));
         chk("fifo_cnt", int'(fifo_cnt), m_cnt);
         chk("ovf", int'(ovf), m_ovf);
         chk("drop_cnt", int'(drop_cnt), m_drop);
         if (ev_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL ev_unexpected: got key %0d expected no event at %0t", ev_key, $time);
            end else begin
               chk("ev_key", int'(ev_key), exp_q[0]);
               if (ev_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input logic [N-1:0] kf, input logic rdy, input logic clr, input logic r);
      key_flag = kf;
      ev_ready = rdy;
      clr_ovf  = clr;
      rst      = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc('0, 1'b0, 1'b0, 1'b1);
      chk("rst_ev_valid", int'(ev_valid), 0);
      chk("rst_ev_key", int'(ev_key), 0);
      chk("rst_fifo_cnt", int'(fifo_cnt), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      mon_en = 1'b1;

      // single press, two-cycle latency
      repeat (8) cyc('0, 1'b1, 1'b0, 1'b0);
      cyc(4'b0100, 1'b1, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0, 1'b0);
      chk("lat_valid", int'(ev_valid), 1);
      chk("lat_key", int'(ev_key), 2);
      cyc('0, 1'b1, 1'b0, 1'b0);
      chk("lat_valid_drop", int'(ev_valid), 0);
      chk("lat_cnt_zero", int'(fifo_cnt), 0);

      // all keys at once fill the FIFO in index order
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b0, 1'b0);
      repeat (6) cyc('0, 1'b0, 1'b0, 1'b0);
      chk("fill_cnt", int'(fifo_cnt), 4);
      chk("fill_ovf", int'(ovf), 0);
      chk("fill_head", int'(ev_key), 0);
      repeat (5) cyc('0, 1'b1, 1'b0, 1'b0);
      chk("drain_cnt", int'(fifo_cnt), 0);

      // full FIFO: second press of key 1 is a drop; pop lets key 1 in next cycle
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b0, 1'b0);
      repeat (6) cyc('0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      chk("full_ovf", int'(ovf), 1);
      chk("full_drop", int'(drop_cnt), 1);
      cyc('0, 1'b1, 1'b0, 1'b0);
      chk("full_pop_blocks", int'(fifo_cnt), 3);
      cyc('0, 1'b0, 1'b0, 1'b0);
      chk("full_regrant", int'(fifo_cnt), 4);
      repeat (6) cyc('0, 1'b1, 1'b0, 1'b0);

      // fairness between keys 0 and 3
      cyc('0, 1'b0, 1'b0, 1'b1);
      repeat (8) begin
         cyc(4'b1001, 1'b1, 1'b0, 1'b0);
         repeat (3) cyc('0, 1'b1, 1'b0, 1'b0);
      end

      // drop counter saturation and clear
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b0, 1'b0);
      repeat (6) cyc('0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0, 1'b0);
      repeat (300) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
      chk("sat_drop", int'(drop_cnt), 255);
      chk("sat_ovf", int'(ovf), 1);
      cyc('0, 1'b0, 1'b1, 1'b0);
      chk("clr_ovf", int'(ovf), 0);
      chk("clr_drop", int'(drop_cnt), 0);
      cyc(4'b0001, 1'b0, 1'b1, 1'b0);
      chk("clr_vs_drop_ovf", int'(ovf), 1);
      chk("clr_vs_drop_cnt", int'(drop_cnt), 1);

      // reset mid-operation discards queued and pending events
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc(4'b0111, 1'b0, 1'b0, 1'b0);
      repeat (4) cyc('0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_cnt", int'(fifo_cnt), 3);
      cyc(4'b1010, 1'b0, 1'b0, 1'b0);
      cyc(4'b0101, 1'b1, 1'b0, 1'b1);
      chk("mid_rst_valid", int'(ev_valid), 0);
      chk("mid_rst_cnt", int'(fifo_cnt), 0);
      chk("mid_rst_key", int'(ev_key), 0);
      repeat (6) cyc('0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_valid", int'(ev_valid), 0);

      // random traffic
      repeat (3000) begin
         for (int i = 0; i < N; i++) rnd_kf[i] = ($urandom_range(0, 5) == 0);
         cyc(rnd_kf, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 299) == 0);
      end
      cyc('0, 1'b1, 1'b0, 1'b0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
